wave_reader: RTL and testbench

WAVE_READER -- requirements
Module: wave_reader

---
 rtl/wave_pkg.sv | 14 +
 rtl/wave_lerp.sv | 31 +++
 rtl/wave_reader.sv | 104 ++++++++++
 tb/tb_wave_reader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared types and default sizes for the wavetable reader.
package wave_pkg;

   localparam int PHASE_SIZE_DEF = 24;
   localparam int FRAC_SIZE_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      OUT
   } state_t;

endpackage

// File: rtl/wave_lerp.sv
// Combinational linear interpolation between two signed table samples.
// The result is d1 + floor((d2-d1)*frac / 2^FRAC_SIZE), wrapped to DATA_SIZE bits.
module wave_lerp #(
   parameter int DATA_SIZE = 8,
   parameter int FRAC_SIZE = 8
) (
   input  logic signed [DATA_SIZE-1:0] i_d1,
   input  logic signed [DATA_SIZE-1:0] i_d2,
   input  logic        [FRAC_SIZE-1:0] i_frac,
   output logic signed [DATA_SIZE-1:0] o_sample
);

   localparam int PROD_SIZE = DATA_SIZE + FRAC_SIZE + 2;

   logic signed [DATA_SIZE:0]   w_diff;
   logic signed [PROD_SIZE-1:0] w_diffExt;
   logic signed [PROD_SIZE-1:0] w_fracExt;
   logic signed [PROD_SIZE-1:0] w_prod;

   // The difference needs one extra bit so a full-scale swing cannot overflow.
   assign w_diff    = {i_d2[DATA_SIZE-1], i_d2} - {i_d1[DATA_SIZE-1], i_d1};

   // Both operands are widened to the product width so the multiply is exact.
   assign w_diffExt = {{(FRAC_SIZE+1){w_diff[DATA_SIZE]}}, w_diff};
   assign w_fracExt = {{(DATA_SIZE+2){1'b0}}, i_frac};
   assign w_prod    = w_diffExt * w_fracExt;

   // Arithmetic shift floors toward minus infinity; the sum wraps without saturation.
   assign o_sample  = i_d1 + DATA_SIZE'(w_prod >>> FRAC_SIZE);

endmodule

// File: rtl/wave_reader.sv
// Phase-accumulating wavetable reader with linear interpolation and a
// valid/ready output. One sample is produced every three cycles: ISSUE
// presents the addresses, CAPTURE interpolates the returned table data,
// OUT holds the sample until it is accepted.
module wave_reader
   import wave_pkg::*;
#(
   parameter int ADDRESS_SIZE = 8,
   parameter int DATA_SIZE    = 8,
   parameter int PHASE_SIZE   = PHASE_SIZE_DEF,
   parameter int FRAC_SIZE    = FRAC_SIZE_DEF
) (
   input  logic                        i_clk,
   input  logic                        i_res,
   input  logic                        i_en,
   input  logic        [PHASE_SIZE-1:0] i_step,
   input  logic                        i_sync,
   output logic      [ADDRESS_SIZE-1:0] o_addr1,
   output logic      [ADDRESS_SIZE-1:0] o_addr2,
   input  logic signed  [DATA_SIZE-1:0] i_data1,
   input  logic signed  [DATA_SIZE-1:0] i_data2,
   output logic signed  [DATA_SIZE-1:0] o_sample,
   output logic                        o_valid,
   input  logic                        i_ready
);

   // PHASE_SIZE must be at least ADDRESS_SIZE + FRAC_SIZE so the fraction
   // field sits entirely below the address field.

   state_t                       r_state;
   state_t                       w_nextState;
   logic        [PHASE_SIZE-1:0] r_phase;
   logic         [FRAC_SIZE-1:0] r_frac;
   logic signed  [DATA_SIZE-1:0] r_sample;
   logic signed  [DATA_SIZE-1:0] w_lerp;
   logic                         w_issue;
   logic                         w_capture;

   assign o_addr1  = r_phase[PHASE_SIZE-1 -: ADDRESS_SIZE];
   assign o_addr2  = o_addr1 + ADDRESS_SIZE'(1);
   assign o_sample = r_sample;

   wave_lerp #(
      .DATA_SIZE (DATA_SIZE),
      .FRAC_SIZE (FRAC_SIZE)
   ) u_lerp (
      .i_d1     (i_data1),
      .i_d2     (i_data2),
      .i_frac   (r_frac),
      .o_sample (w_lerp)
   );

   // Next-state decode plus the per-state strobes and the valid flag.
   always_comb begin
      w_nextState = r_state;
      w_issue     = 1'b0;
      w_capture   = 1'b0;
      o_valid     = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_en) w_nextState = ISSUE;
         end
         ISSUE: begin
            w_issue     = 1'b1;
            w_nextState = CAPTURE;
         end
         CAPTURE: begin
            w_capture   = 1'b1;
            w_nextState = OUT;
         end
         OUT: begin
            o_valid = 1'b1;
            if (i_ready) w_nextState = i_en ? ISSUE : IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_res) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   // Phase accumulator; a sync pulse clears it and beats the ISSUE increment.
   always_ff @(posedge i_clk) begin
      if (i_res)        r_phase <= '0;
      else if (i_sync)  r_phase <= '0;
      else if (w_issue) r_phase <= r_phase + i_step;
   end

   // Fraction is captured alongside the addresses so it matches the returned data.
   always_ff @(posedge i_clk) begin
      if (i_res)        r_frac <= '0;
      else if (w_issue) r_frac <= r_phase[PHASE_SIZE-ADDRESS_SIZE-1 -: FRAC_SIZE];
   end

   // Output sample register, loaded once per sample and held through OUT.
   always_ff @(posedge i_clk) begin
      if (i_res)          r_sample <= '0;
      else if (w_capture) r_sample <= w_lerp;
   end

endmodule

// File: tb/tb_wave_reader.sv
// Scoreboard bench for wave_reader: expected samples are queued from a
// phase-arithmetic reference model, a monitor pops them on each transfer.
module tb_wave_reader;

   logic               clk = 1'b0;
   logic               res;
   logic               en;
   logic        [23:0] step;
   logic               sync;
   logic         [7:0] addr1;
   logic         [7:0] addr2;
   logic signed  [7:0] data1;
   logic signed  [7:0] data2;
   logic signed  [7:0] sample;
   logic               valid;
   logic               ready;

   int                 checks = 0;
   int                 errors = 0;
   int                 expQ[$];
   logic        [23:0] mPhase;

   always #5 clk = ~clk;

   wave_reader dut (
      .i_clk    (clk),
      .i_res    (res),
      .i_en     (en),
      .i_step   (step),
      .i_sync   (sync),
      .o_addr1  (addr1),
      .o_addr2  (addr2),
      .i_data1  (data1),
      .i_data2  (data2),
      .o_sample (sample),
      .o_valid  (valid),
      .i_ready  (ready)
   );

   // Registered wavetable holding data[k] = k - 128.
   always @(posedge clk) begin
      data1 <= addr1 - 8'd128;
      data2 <= addr2 - 8'd128;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference sample for a phase value, from the table formula and floor division.
   function automatic int refSample(input logic [23:0] ph);
      int a, f, d1, d2, p, q;
      a  = int'(ph[23:16]);
      f  = int'(ph[15:8]);
      d1 = a - 128;
      d2 = ((a + 1) % 256) - 128;
      p  = (d2 - d1) * f;
      if (p >= 0) q = p / 256;
      else        q = -((-p + 255) / 256);
      return d1 + q;
   endfunction

   task automatic pushExpected(input int n, input logic [23:0] stepVal);
      for (int k = 0; k < n; k++) begin
         expQ.push_back(refSample(mPhase));
         mPhase = mPhase + stepVal;
      end
   endtask

   // Runs from IDLE until n transfers; optional sync pulse and early enable drop.
   task automatic applyStimulus(input int n, input bit rndReady, input int syncIter, input int dropIter);
      int got, it, firstIt, lastIt, idleValid;
      got     = 0;
      it      = 0;
      firstIt = -1;
      lastIt  = -1;
      en      = 1'b1;
      while (got < n && it < 400) begin
         @(negedge clk);
         it++;
         sync  = (it == syncIter);
         if (it == dropIter) en = 1'b0;
         ready = rndReady ? 1'($urandom_range(0, 1)) : 1'b1;
         if (valid && ready) begin
            got++;
            if (firstIt < 0) begin
               firstIt = it;
               if (!rndReady) checkOutput("latency", firstIt, 3);
            end else if (!rndReady) begin
               checkOutput("spacing", it - lastIt, 3);
            end
            lastIt = it;
            if (got == n) en = 1'b0;
         end
      end
      sync = 1'b0;
      checkOutput("transfers", got, n);
      idleValid = 0;
      repeat (6) begin
         @(negedge clk);
         ready = 1'b1;
         if (valid) idleValid++;
      end
      checkOutput("idle after burst", idleValid, 0);
   endtask

   task automatic syncInIdle();
      @(negedge clk);
      sync = 1'b1;
      @(negedge clk);
      sync   = 1'b0;
      mPhase = '0;
      checkOutput("sync addr1", int'(addr1), 0);
   endtask

   // Monitor: every accepted sample is compared with the head of the queue.
   initial begin
      int expVal;
      forever begin
         @(negedge clk);
         #1;
         if (!res && valid && ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected sample", int'(sample), -999);
            end else begin
               expVal = expQ.pop_front();
               checkOutput("sample", int'(sample), expVal);
            end
         end
      end
   end

   initial begin
      logic        [23:0] nextPhase;
      logic signed  [7:0] heldSample;
      int                 waitCnt;

      res    = 1'b1;
      en     = 1'b0;
      step   = '0;
      sync   = 1'b0;
      ready  = 1'b1;
      mPhase = '0;

      // Reset held for two edges.
      repeat (2) @(negedge clk);
      checkOutput("reset valid", int'(valid), 0);
      checkOutput("reset sample", int'(sample), 0);
      checkOutput("reset addr1", int'(addr1), 0);
      checkOutput("reset addr2", int'(addr2), 1);
      res = 1'b0;
      @(negedge clk);

      // Plain stepping through the table.
      step = 24'h010000;
      pushExpected(3, step);
      applyStimulus(3, 1'b0, -1, -1);

      // Table wrap with half-way interpolation.
      syncInIdle();
      step = 24'hFF8000;
      pushExpected(3, step);
      applyStimulus(3, 1'b0, -1, -1);

      // Backpressure: output must hold while ready is low.
      step = 24'h010000;
      expQ.push_back(refSample(mPhase));
      nextPhase = mPhase + step;
      mPhase    = nextPhase;
      ready     = 1'b0;
      en        = 1'b1;
      waitCnt   = 0;
      while (!valid && waitCnt < 20) begin
         @(negedge clk);
         waitCnt++;
      end
      checkOutput("bp valid rise", int'(valid), 1);
      heldSample = sample;
      repeat (5) begin
         @(negedge clk);
         checkOutput("bp valid held", int'(valid), 1);
         checkOutput("bp sample held", int'(sample), int'(heldSample));
         checkOutput("bp addr1", int'(addr1), int'(nextPhase[23:16]));
      end
      ready = 1'b1;
      en    = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("bp idle valid", int'(valid), 0);
      pushExpected(1, step);
      applyStimulus(1, 1'b0, -1, -1);

      // Enable dropped during CAPTURE: the sample still arrives, then IDLE.
      pushExpected(1, step);
      applyStimulus(1, 1'b0, -1, 2);

      // Sync pulse during ISSUE: current sample unaffected, next from address 0.
      expQ.push_back(refSample(mPhase));
      mPhase = '0;
      pushExpected(1, step);
      applyStimulus(2, 1'b0, 1, -1);

      // Reset in the middle of a sample aborts it.
      en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      res = 1'b1;
      en  = 1'b0;
      @(negedge clk);
      checkOutput("midreset valid", int'(valid), 0);
      checkOutput("midreset addr1", int'(addr1), 0);
      checkOutput("midreset addr2", int'(addr2), 1);
      res    = 1'b0;
      mPhase = '0;
      pushExpected(1, step);
      applyStimulus(1, 1'b0, -1, -1);

      // Randomized bursts with random steps, random ready and occasional syncs.
      for (int b = 0; b < 8; b++) begin
         int n;
         if ($urandom_range(0, 2) == 0) syncInIdle();
         step = 24'($urandom);
         n    = int'($urandom_range(1, 4));
         pushExpected(n, step);
         applyStimulus(n, 1'($urandom_range(0, 1)), -1, -1);
      end

      checkOutput("queue empty", expQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
